// File: rtl/venus_mem_pkg.sv
// Shared definitions for the instruction-memory subsystem: the arbiter state
// encoding, the memory geometry and the instruction fetch substitutes while stalled.
package venus_mem_pkg;

    typedef enum logic {
        F_OWN = 1'b0,
        L_OWN = 1'b1
    } arb_state_e;

    localparam int IMEM_ADDR = 16;
    localparam int IMEM_WORD = 32;

    localparam logic [IMEM_WORD-1:0] NOP_INST = 32'h3C00_0000;

endpackage

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction memory between fetch (priority, read-only)
// and the loader/debug port, with a wait counter and bounded bursts for loader progress.
module imem_port_arbiter
    import venus_mem_pkg::*;
#(
    parameter int ADDR     = IMEM_ADDR,
    parameter int WORD     = IMEM_WORD,
    parameter int MAX_WAIT = 8,
    parameter int BURST    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            f_req,
    input  logic [ADDR-1:0] f_addr,
    output logic            f_gnt,
    output logic            f_valid,
    output logic [WORD-1:0] f_q,
    output logic            fetch_stall,
    input  logic            l_req,
    input  logic            l_we,
    input  logic [ADDR-1:0] l_addr,
    input  logic [WORD-1:0] l_d,
    output logic            l_gnt,
    output logic            l_valid,
    output logic [WORD-1:0] l_q,
    output logic [ADDR-1:0] mem_a,
    output logic            mem_w,
    output logic [WORD-1:0] mem_d,
    input  logic [WORD-1:0] mem_q
);

    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [WW-1:0] WAIT_LAST  = WW'(MAX_WAIT - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);

    arb_state_e    state_q, state_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic          f_valid_q, l_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= F_OWN;
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
            f_valid_q   <= 1'b0;
            l_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            f_valid_q   <= f_gnt;
            l_valid_q   <= l_gnt & ~l_we;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        burst_cnt_d = burst_cnt_q;
        f_gnt       = 1'b0;
        l_gnt       = 1'b0;
        fetch_stall = 1'b0;
        if (!rst) begin
            case (state_q)
                F_OWN: begin
                    f_gnt = f_req;
                    l_gnt = l_req & ~f_req;
                    if (l_gnt || !l_req) begin
                        wait_cnt_d = '0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        // Loader starved long enough: hand it the memory for a burst.
                        state_d     = L_OWN;
                        wait_cnt_d  = '0;
                        burst_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
                L_OWN: begin
                    l_gnt       = l_req;
                    fetch_stall = f_req;
                    wait_cnt_d  = '0;
                    if (!l_req || burst_cnt_q == BURST_LAST) begin
                        state_d     = F_OWN;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end
                default: state_d = F_OWN;
            endcase
        end
    end

    assign mem_a   = l_gnt ? l_addr : f_addr;
    assign mem_w   = l_gnt & l_we;
    assign mem_d   = l_d;
    assign f_valid = f_valid_q;
    assign l_valid = l_valid_q;
    assign f_q     = mem_q;
    assign l_q     = mem_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural 1-cycle-latency memory.
module tb_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, l_req, l_we;
    logic [15:0] f_addr, l_addr;
    logic [31:0] l_d;
    logic        f_gnt, f_valid, fetch_stall, l_gnt, l_valid, mem_w;
    logic [31:0] f_q, l_q, mem_d, mem_q;
    logic [15:0] mem_a;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    imem_port_arbiter #(.ADDR(16), .WORD(32), .MAX_WAIT(8), .BURST(4)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_q(f_q),
        .fetch_stall(fetch_stall),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_d(l_d),
        .l_gnt(l_gnt), .l_valid(l_valid), .l_q(l_q),
        .mem_a(mem_a), .mem_w(mem_w), .mem_d(mem_d), .mem_q(mem_q)
    );

    always @(posedge clk) begin
        if (mem_w) mem[mem_a[7:0]] <= mem_d;
        mem_q <= mem_w ? mem_d : mem[mem_a[7:0]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step();
        f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; f_req = 1'b1; l_req = 1'b1; l_we = 1'b1;
        step(); step();
        #1;
        checks++;
        if ({f_gnt, l_gnt, fetch_stall, mem_w} !== 4'b0000) begin
            errors++; $display("FAIL reset_outputs got %b want 0000", {f_gnt, l_gnt, fetch_stall, mem_w});
        end
        checks++;
        if ({f_valid, l_valid} !== 2'b00) begin
            errors++; $display("FAIL reset_valids got %b want 00", {f_valid, l_valid});
        end
        step();
        rst = 1'b0; f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
    endtask

    task automatic test_fetch_stream();
        for (int i = 0; i < 4; i++) begin
            step();
            f_req = 1'b1; f_addr = 16'(i); l_req = 1'b0;
            #1;
            checks++;
            if ({f_gnt, l_gnt, fetch_stall} !== 3'b100) begin
                errors++; $display("FAIL fetch_gnt[%0d] got %b want 100", i, {f_gnt, l_gnt, fetch_stall});
            end
            checks++;
            if (mem_a !== 16'(i)) begin
                errors++; $display("FAIL fetch_mem_a[%0d] got %h want %h", i, mem_a, 16'(i));
            end
            if (i > 0) begin
                checks++;
                if (f_valid !== 1'b1 || f_q !== 32'hA000_0000 + 32'(i - 1)) begin
                    errors++; $display("FAIL fetch_data[%0d] got v=%b q=%h want v=1 q=%h",
                                       i, f_valid, f_q, 32'hA000_0000 + 32'(i - 1));
                end
            end
        end
        step();
        f_req = 1'b0;
        #1;
        checks++;
        if (f_valid !== 1'b1 || f_q !== 32'hA000_0003) begin
            errors++; $display("FAIL fetch_last got v=%b q=%h want v=1 q=a0000003", f_valid, f_q);
        end
        step();
        checks++;
        if (f_valid !== 1'b0) begin
            errors++; $display("FAIL fetch_valid_drop got %b want 0", f_valid);
        end
    endtask

    task automatic test_loader_write_read();
        step();
        f_req = 1'b0; l_req = 1'b1; l_we = 1'b1; l_addr = 16'h0010; l_d = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({l_gnt, mem_w, mem_a, mem_d} !== {1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL ld_write got gnt=%b w=%b a=%h d=%h want 1 1 0010 deadbeef",
                               l_gnt, mem_w, mem_a, mem_d);
        end
        step();
        l_we = 1'b0;
        #1;
        checks++;
        if ({l_gnt, mem_w, l_valid} !== 3'b100) begin
            errors++; $display("FAIL ld_read_gnt got %b want 100", {l_gnt, mem_w, l_valid});
        end
        step();
        l_req = 1'b0;
        #1;
        checks++;
        if (l_valid !== 1'b1 || l_q !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL ld_read_data got v=%b q=%h want v=1 q=deadbeef", l_valid, l_q);
        end
    endtask

    task automatic test_takeover_pattern();
        logic [2:0] exp;
        for (int c = 0; c < 24; c++) begin
            step();
            f_req = 1'b1; l_req = 1'b1; l_we = 1'b0;
            #1;
            exp = ((c % 12) < 8) ? 3'b100 : 3'b011;
            checks++;
            if ({f_gnt, l_gnt, fetch_stall} !== exp) begin
                errors++; $display("FAIL takeover[%0d] got %b want %b", c, {f_gnt, l_gnt, fetch_stall}, exp);
            end
        end
        idle();
    endtask

    task automatic test_burst_abort();
        logic [2:0] exp;
        for (int c = 0; c < 10; c++) begin
            step();
            f_req = 1'b1; l_req = 1'b1; l_we = 1'b0;
            #1;
            exp = (c < 8) ? 3'b100 : 3'b011;
            checks++;
            if ({f_gnt, l_gnt, fetch_stall} !== exp) begin
                errors++; $display("FAIL abort_pre[%0d] got %b want %b", c, {f_gnt, l_gnt, fetch_stall}, exp);
            end
        end
        step();
        l_req = 1'b0;
        #1;
        checks++;
        if ({f_gnt, l_gnt, fetch_stall} !== 3'b001) begin
            errors++; $display("FAIL abort_drop got %b want 001", {f_gnt, l_gnt, fetch_stall});
        end
        // Full 8+4 cycle afterwards shows wait and burst counters both restarted at zero.
        for (int c = 0; c < 13; c++) begin
            step();
            l_req = 1'b1;
            #1;
            exp = (c < 8 || c == 12) ? 3'b100 : 3'b011;
            checks++;
            if ({f_gnt, l_gnt, fetch_stall} !== exp) begin
                errors++; $display("FAIL abort_post[%0d] got %b want %b", c, {f_gnt, l_gnt, fetch_stall}, exp);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_burst();
        logic [2:0] exp;
        for (int c = 0; c < 9; c++) begin
            step();
            f_req = 1'b1; l_req = 1'b1; l_we = 1'b0;
            #1;
            exp = (c < 8) ? 3'b100 : 3'b011;
            checks++;
            if ({f_gnt, l_gnt, fetch_stall} !== exp) begin
                errors++; $display("FAIL rstmid_pre[%0d] got %b want %b", c, {f_gnt, l_gnt, fetch_stall}, exp);
            end
        end
        step();
        rst = 1'b1;
        #1;
        checks++;
        if ({f_gnt, l_gnt, fetch_stall, mem_w} !== 4'b0000) begin
            errors++; $display("FAIL rstmid_gnt got %b want 0000", {f_gnt, l_gnt, fetch_stall, mem_w});
        end
        step();
        rst = 1'b0;
        #1;
        checks++;
        if ({f_valid, l_valid} !== 2'b00) begin
            errors++; $display("FAIL rstmid_valid got %b want 00", {f_valid, l_valid});
        end
        checks++;
        if ({f_gnt, l_gnt, fetch_stall} !== 3'b100) begin
            errors++; $display("FAIL rstmid_state got %b want 100", {f_gnt, l_gnt, fetch_stall});
        end
        for (int c = 1; c < 9; c++) begin
            step();
            #1;
            exp = (c < 8) ? 3'b100 : 3'b011;
            checks++;
            if ({f_gnt, l_gnt, fetch_stall} !== exp) begin
                errors++; $display("FAIL rstmid_post[%0d] got %b want %b", c, {f_gnt, l_gnt, fetch_stall}, exp);
            end
        end
        idle();
    endtask

    task automatic test_write_strobe();
        for (int c = 0; c < 12; c++) begin
            step();
            f_req = 1'b1; l_req = 1'b1; l_we = 1'b1; l_addr = 16'h0020; l_d = 32'h1234_0000 + 32'(c);
            #1;
            checks++;
            if ({mem_w, l_gnt, l_valid} !== {c >= 8, c >= 8, 1'b0}) begin
                errors++; $display("FAIL wstrobe[%0d] got w=%b gnt=%b lv=%b want w=%b gnt=%b lv=0",
                                   c, mem_w, l_gnt, l_valid, c >= 8, c >= 8);
            end
        end
        step();
        f_req = 1'b0; l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0020;
        step();
        l_req = 1'b0;
        #1;
        checks++;
        if (l_valid !== 1'b1 || l_q !== 32'h1234_000B) begin
            errors++; $display("FAIL wstrobe_readback got v=%b q=%h want v=1 q=1234000b", l_valid, l_q);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
        rst = 1'b1; f_req = 1'b0; l_req = 1'b0; l_we = 1'b0;
        f_addr = '0; l_addr = '0; l_d = '0;
        test_reset();
        test_fetch_stream();
        test_loader_write_read();
        test_takeover_pattern();
        test_burst_abort();
        test_reset_mid_burst();
        test_write_strobe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
